// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Holds the stage occupancy encoding, default bundle widths per pipeline
// boundary, and bit positions of the named control fields inside a ctrl bundle.
package pipe_pkg;

  // Occupancy is {skid_v, main_v}; 2'b10 cannot occur in normal operation.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } pipe_state_e;

  // Default bundle widths for each pipeline boundary.
  localparam int IFID_CTRL_W  = 16;
  localparam int IFID_DATA_W  = 64;   // pc, instruction
  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 176;  // pc, rs1/rs2 values, imm, rd/rs indices
  localparam int EXMEM_CTRL_W = 16;
  localparam int EXMEM_DATA_W = 112;  // alu result, store data, rd, branch target
  localparam int MEMWB_CTRL_W = 16;
  localparam int MEMWB_DATA_W = 80;   // load data, alu result, rd

  // Control field positions inside a ctrl bundle. An all-zero bundle is a NOP.
  localparam int CTRL_REG_WRITE_BIT = 0;
  localparam int CTRL_MEM_WRITE_BIT = 1;
  localparam int CTRL_MEM_READ_BIT  = 2;
  localparam int CTRL_BRANCH_BIT    = 3;
  localparam int CTRL_ALU_CTRL_LSB  = 4;
  localparam int CTRL_ALU_CTRL_W    = 4;
  localparam int CTRL_MEM_TO_REG_BIT = 8;
  localparam int CTRL_ALU_SRC_BIT   = 9;
  localparam int CTRL_JUMP_BIT      = 10;

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register carrying ctrl + data bundles over valid/ready.
// Latency 1 cycle; optional 2-entry skid keeps full throughput with in_ready registered.
// Backpressure: SKID_EN=1 in_ready = !skid_v; SKID_EN=0 in_ready = !main_v | out_ready.
// Ports: Clk/Rst (sync, active-high); in_valid/in_ready/ctrl_in/data_in upstream;
//   out_valid/out_ready/ctrl_out/data_out downstream; flush empties the stage;
//   bubble_cnt counts cycles with out_valid=0, saturating.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = 16,
  parameter int DATA_W  = 176,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e state, state_nxt;

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;

  assign main_v = state[0];
  assign skid_v = state[1];

  // With the skid buffer, in_ready is a pure register output so no
  // combinational ready path crosses the stage.
  assign in_ready  = SKID_EN ? !skid_v : (!main_v | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = main_v;
  assign out_fire  = main_v & out_ready;

  assign ctrl_out = main_v ? main_ctrl : '0;
  assign data_out = main_data;

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Any beat accepted this cycle is swallowed; payload regs keep their contents.
      state_nxt = ST_EMPTY;
    end else if (SKID_EN) begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = ST_SKID;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = ST_FULL;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end else begin
      if (in_fire) begin
        load_main_in = 1'b1;
        state_nxt    = ST_FULL;
      end else if (out_fire) begin
        state_nxt = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= ctrl_in;
        main_data <= data_in;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= ctrl_in;
        skid_data <= data_in;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bubble_cnt <= '0;
    end else if (!main_v && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int CW = 16;
  localparam int DW = 176;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  // u0: skid enabled, default widths
  logic          iv0 = 1'b0, or0 = 1'b0, fl0 = 1'b0;
  logic [CW-1:0] c0 = '0;
  logic [DW-1:0] d0 = '0;
  logic          ir0, ov0;
  logic [CW-1:0] co0;
  logic [DW-1:0] do0;
  logic [15:0]   bc0;

  // u1: no skid
  logic          iv1 = 1'b0, or1 = 1'b0, fl1 = 1'b0;
  logic [CW-1:0] c1 = '0;
  logic [DW-1:0] d1 = '0;
  logic          ir1, ov1;
  logic [CW-1:0] co1;
  logic [DW-1:0] do1;
  logic [15:0]   bc1;

  // u2: CNT_W=4, idle input
  logic          iv2 = 1'b0, or2 = 1'b1, fl2 = 1'b0;
  logic [CW-1:0] c2 = '0;
  logic [DW-1:0] d2 = '0;
  logic          ir2, ov2;
  logic [CW-1:0] co2;
  logic [DW-1:0] do2;
  logic [3:0]    bc2;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .CNT_W(16)) u0 (
    .Clk(Clk), .Rst(Rst), .in_valid(iv0), .in_ready(ir0), .ctrl_in(c0), .data_in(d0),
    .flush(fl0), .out_valid(ov0), .out_ready(or0), .ctrl_out(co0), .data_out(do0),
    .bubble_cnt(bc0));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0), .CNT_W(16)) u1 (
    .Clk(Clk), .Rst(Rst), .in_valid(iv1), .in_ready(ir1), .ctrl_in(c1), .data_in(d1),
    .flush(fl1), .out_valid(ov1), .out_ready(or1), .ctrl_out(co1), .data_out(do1),
    .bubble_cnt(bc1));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1), .CNT_W(4)) u2 (
    .Clk(Clk), .Rst(Rst), .in_valid(iv2), .in_ready(ir2), .ctrl_in(c2), .data_in(d2),
    .flush(fl2), .out_valid(ov2), .out_ready(or2), .ctrl_out(co2), .data_out(do2),
    .bubble_cnt(bc2));

  // Reference model: each stage is a bounded FIFO (capacity 2 with skid, 1 without).
  beat_t         q0[$], q1[$];
  logic [DW-1:0] last0 = '0, last1 = '0;
  int            bub0 = 0, bub1 = 0, bub2 = 0;
  bit            seen42 = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[32*i +: 32] = $urandom();
    return r[DW-1:0];
  endfunction

  // Check all outputs against the model, then advance one clock edge.
  task automatic step();
    bit fi0, fo0, fi1, fo1;
    #1;
    chk("u0.out_valid", 192'(ov0), 192'(q0.size() > 0));
    chk("u0.ctrl_out",  192'(co0), 192'((q0.size() > 0) ? q0[0].c : '0));
    chk("u0.data_out",  192'(do0), 192'((q0.size() > 0) ? q0[0].d : last0));
    chk("u0.in_ready",  192'(ir0), 192'(q0.size() < 2));
    chk("u0.bubble",    192'(bc0), 192'(bub0));
    chk("u1.out_valid", 192'(ov1), 192'(q1.size() > 0));
    chk("u1.ctrl_out",  192'(co1), 192'((q1.size() > 0) ? q1[0].c : '0));
    chk("u1.data_out",  192'(do1), 192'((q1.size() > 0) ? q1[0].d : last1));
    chk("u1.in_ready",  192'(ir1), 192'((q1.size() == 0) || or1));
    chk("u2.bubble",    192'(bc2), 192'(bub2));
    if (ov0 && co0 == 16'h0042) seen42 = 1'b1;

    fi0 = !Rst && iv0 && (q0.size() < 2);
    fo0 = !Rst && (q0.size() > 0) && or0;
    fi1 = !Rst && iv1 && ((q1.size() == 0) || or1);
    fo1 = !Rst && (q1.size() > 0) && or1;

    @(posedge Clk);
    if (Rst) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      bub0 = 0; bub1 = 0; bub2 = 0;
    end else begin
      if (q0.size() == 0 && bub0 < 65535) bub0++;
      if (q1.size() == 0 && bub1 < 65535) bub1++;
      if (bub2 < 15) bub2++;
      if (q0.size() > 0) last0 = q0[0].d;
      if (q1.size() > 0) last1 = q1[0].d;
      if (fo0) void'(q0.pop_front());
      if (fo1) void'(q1.pop_front());
      if (fl0) q0.delete();
      else if (fi0) q0.push_back('{c: c0, d: d0});
      if (fl1) q1.delete();
      else if (fi1) q1.push_back('{c: c1, d: d1});
      if (q0.size() > 0) last0 = q0[0].d;
      if (q1.size() > 0) last1 = q1[0].d;
    end
    @(negedge Clk);
  endtask

  task automatic put0(input logic v, input logic [CW-1:0] c, input logic r, input logic f);
    iv0 = v; c0 = c; d0 = rnd_data(); or0 = r; fl0 = f;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two edges with junk on the input.
    Rst = 1'b1; iv0 = 1'b1; c0 = 16'hFFFF; d0 = '1; or0 = 1'b1;
    iv1 = 1'b1; c1 = 16'hFFFF; d1 = '1; or1 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    step();
    Rst = 1'b0; iv0 = 1'b0; iv1 = 1'b0;
    step();

    // Streaming with no backpressure.
    for (int i = 1; i <= 8; i++) begin
      put0(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b0);
      step();
    end
    put0(1'b0, '0, 1'b1, 1'b0);
    step();

    // A, B, C with backpressure after A is presented.
    put0(1'b1, 16'h00A1, 1'b1, 1'b0); step();
    put0(1'b1, 16'h00B2, 1'b1, 1'b0); step();
    put0(1'b1, 16'h00C3, 1'b0, 1'b0); step();
    put0(1'b1, 16'h00D4, 1'b0, 1'b0); step();
    put0(1'b0, '0,       1'b0, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      put0(1'b0, '0, 1'b1, 1'b0); step();
    end

    // Fill to SKID, then flush with a beat offered.
    put0(1'b1, 16'h0011, 1'b0, 1'b0); step();
    put0(1'b1, 16'h0022, 1'b0, 1'b0); step();
    put0(1'b1, 16'h0042, 1'b0, 1'b1); step();
    put0(1'b1, 16'h0042, 1'b0, 1'b1); step();
    // Flush in FULL while a beat fires in and out.
    put0(1'b1, 16'h0033, 1'b1, 1'b0); step();
    put0(1'b1, 16'h0042, 1'b1, 1'b1); step();
    put0(1'b0, '0, 1'b1, 1'b0); step();
    chk("no_0042_out", 192'(seen42), 192'(0));

    // No-skid instance with out_ready toggling and steady input offer.
    iv1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c1 = 16'h5000 + 16'(i); d1 = rnd_data(); or1 = i[0] ? 1'b0 : 1'b1;
      step();
    end
    iv1 = 1'b0; or1 = 1'b1;
    step();

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      put0(1'($urandom_range(0, 3) != 0), 16'($urandom()), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0));
      iv1 = 1'($urandom_range(0, 3) != 0); c1 = 16'($urandom()); d1 = rnd_data();
      or1 = 1'($urandom_range(0, 2) != 0); fl1 = 1'($urandom_range(0, 24) == 0);
      step();
    end
    put0(1'b0, '0, 1'b1, 1'b0);
    iv1 = 1'b0; or1 = 1'b1; fl1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("u0.drained", 192'(ov0), 192'(0));
    chk("u2.bubble_sat", 192'(bc2), 192'(15));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register, the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle between stages using a valid/ready handshake. A 2-entry skid buffer keeps full throughput under backpressure. It also provides flush-to-bubble and a saturating bubble counter for performance monitoring.

Parameters:
CTRL_W, 16, width of control bundle (regWrite, memWrite, memRead, branch, aluControl, ...); all-zero value = bubble/NOP
DATA_W, 176, width of data bundle (pc, operands, immediate, register indices, ...)
SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single entry, in_ready combinationally follows out_ready
CNT_W, 16, width of bubble counter

Ports:
Clk  in  1  clock, all state on rising edge
Rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat
ctrl_in  in  CTRL_W  upstream control bundle
data_in  in  DATA_W  upstream data bundle
flush  in  1  discard all held beats (branch taken / exception)
out_valid  out  1  downstream beat present
out_ready  in  1  downstream accepts
ctrl_out  out  CTRL_W  control to next stage; forced 0 when out_valid=0
data_out  out  DATA_W  data to next stage; holds last main-entry value when invalid
bubble_cnt  out  CNT_W  cycles with out_valid=0 since reset, saturating

Behaviour:
- Clock Clk; reset Rst is synchronous and active-high. Reset priority is above everything else.
- Reset values:
  - main and skid entries invalid, all entry fields 0
  - out_valid=0, ctrl_out=0, data_out=0, bubble_cnt=0
  - in_ready=1 in the first cycle after reset.
- Handshake:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
  - Beats are never duplicated, dropped (except by flush) or reordered.
- Latency: 1 cycle. A beat accepted at edge N appears on the outputs after edge N, provided the stage was EMPTY or out_fire occurred.
- State machine (SKID_EN=1), state = {skid_v, main_v}:
  - EMPTY:
    - in_fire -> FULL
  - FULL:
    - in_fire & out_fire -> FULL (main <= input)
    - in_fire & !out_fire -> SKID (skid <= input)
    - !in_fire & out_fire -> EMPTY
  - SKID:
    - in_ready=0
    - out_fire -> FULL (main <= skid)
- in_ready = !skid_v. It is driven from a register only; there is no combinational path from out_ready.
- SKID_EN=0:
  - in_ready = !main_v | out_ready
  - State is EMPTY/FULL only.
- out_valid = main_v. ctrl_out = main_v ? main_ctrl : 0.
- Flush:
  - When flush=1 (and Rst=0), both entries become invalid at the next edge.
  - Any in_fire in the same cycle is consumed and discarded.
  - Data fields are not cleared.
  - The next cycle shows out_valid=0, ctrl_out=0, in_ready=1.
- flush with out_fire in the same cycle: the downstream beat counts as delivered, and the flush still empties the stage.
- bubble_cnt:
  - increments on every edge where out_valid=0 (Rst=0)
  - saturates at 2^CNT_W-1
  - clears only on Rst.
- Widths: there is no arithmetic on payloads; fields pass bit-exact. Only bubble_cnt uses an adder.

Decomposition:
- Package pipe_pkg holds:
  - state encodings ST_EMPTY=2'b00, ST_FULL=2'b01, ST_SKID=2'b11
  - default CTRL_W/DATA_W per stage (IFID/IDEX/EXMEM/MEMWB)
  - localparam bit offsets of control fields within ctrl bundles
- No sub-module. One instance is made per pipeline boundary. Stage wrappers pack and unpack the named fields.

Test Plan:
1. Rst=1 for 2 cycles with in_valid=1, ctrl_in=16'hFFFF -> out_valid=0, ctrl_out=0, data_out=0, bubble_cnt=0, in_ready=1 after release.
2. Stream A1..A8 with out_ready=1 -> each value appears exactly 1 cycle after acceptance, in_ready stays 1, no gaps.
3. Feed A,B,C; drop out_ready after A is presented -> B is held in main, C goes to skid, in_ready=0. Raise out_ready -> B, then C delivered in order, in_ready returns to 1.
4. Stage in SKID state, assert flush with in_valid=1 (ctrl_in=16'h0042) -> next cycle out_valid=0, ctrl_out=0, in_ready=1, and 16'h0042 never appears on the output.
5. CNT_W=4, idle input for 20 cycles after reset -> bubble_cnt reads 15 and stays at 15.
6. SKID_EN=0, out_ready toggling 1/0 each cycle with constant input -> in_ready equals !main_v|out_ready combinationally, all beats delivered in order with no duplicates.
